// File: rtl/operand_serializer.sv
// Parallel-to-serial feeder for the 2-bit serial adder: FIFO-buffered operand pairs, MSB-first, fixed launch period.
// Optional rejected-push counter enabled by defining OPERAND_SERIALIZER_REJECT_CNT_EN.
module operand_serializer #(
    parameter int WIDTH = 2,
    parameter int GAP   = 4,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_a,
    input  logic [WIDTH-1:0]        in_b,
    output logic                    add_en,
    output logic                    add_a,
    output logic                    add_b,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  level,
    output logic [7:0]              rej_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH + GAP + 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(WIDTH + GAP - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [PW:0]   FULL_LVL   = (PW+1)'(DEPTH);
    localparam logic [PW:0]   LVL_ONE    = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    typedef enum logic [1:0] {S_DRAIN, S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic               add_en_q, add_en_d;
    logic               add_a_q, add_a_d;
    logic               add_b_q, add_b_d;

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [2*WIDTH-1:0] head;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]        level_q, level_d;
    logic               push, pop, fifo_empty, fifo_full;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FULL_LVL);
    // Pushes are refused while draining so nothing queues up behind a reset.
    assign in_ready   = !fifo_full && (state_q != S_DRAIN);
    assign push       = in_valid && in_ready;
    assign head       = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // State register, including the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_DRAIN;
            cnt_q    <= DRAIN_LAST;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            add_en_q <= 1'b0;
            add_a_q  <= 1'b0;
            add_b_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            add_en_q <= add_en_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Next-state logic; one counter serves drain, bit and gap timing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_SHIFT;
                    cnt_d   = BIT_LAST;
                end
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_SHIFT;
                        cnt_d   = BIT_LAST;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_DRAIN;
                cnt_d   = DRAIN_LAST;
            end
        endcase
    end

    // Output logic: the bit presented next cycle is the MSB of the next shift-register value.
    always_comb begin
        sh_a_d = sh_a_q;
        sh_b_d = sh_b_q;
        if (pop) begin
            sh_a_d = head[2*WIDTH-1:WIDTH];
            sh_b_d = head[WIDTH-1:0];
        end else if (state_q == S_SHIFT) begin
            sh_a_d = sh_a_q << 1;
            sh_b_d = sh_b_q << 1;
        end
        add_en_d = pop;
        add_a_d  = (state_d == S_SHIFT) && sh_a_d[WIDTH-1];
        add_b_d  = (state_d == S_SHIFT) && sh_b_d[WIDTH-1];
    end

    assign add_en = add_en_q;
    assign add_a  = add_a_q;
    assign add_b  = add_b_q;
    assign level  = level_q;
    assign busy   = (state_q != S_IDLE) || !fifo_empty;

`ifdef OPERAND_SERIALIZER_REJECT_CNT_EN
    logic [7:0] rej_cnt_q, rej_cnt_d;

    always_comb begin
        rej_cnt_d = rej_cnt_q;
        if (in_valid && !in_ready && (rej_cnt_q != 8'hFF)) begin
            rej_cnt_d = rej_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_cnt_q <= 8'd0;
        end else begin
            rej_cnt_q <= rej_cnt_d;
        end
    end

    assign rej_cnt = rej_cnt_q;
`else
    assign rej_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_operand_serializer.sv
// Randomized scoreboard bench for operand_serializer: expected pairs queued at push, serial stream checked by a monitor.
module tb_operand_serializer;
    localparam int W = 2;
    localparam int G = 4;
    localparam int D = 4;
    localparam int P = W + G;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           add_en, add_a, add_b, busy;
    logic [$clog2(D):0] level;
    logic [7:0]     rej_cnt;

    pair_t          exp_q[$];
    logic [2*W-1:0] rx_q[$];
    int             en_times[$];
    int             n_cmp = 0;
    int             n_bad = 0;
    int             rej_seen = 0;

    operand_serializer #(.WIDTH(W), .GAP(G), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .add_en   (add_en),
        .add_a    (add_a),
        .add_b    (add_b),
        .busy     (busy),
        .level    (level),
        .rej_cnt  (rej_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int rej_expected();
`ifdef OPERAND_SERIALIZER_REJECT_CNT_EN
        return (rej_seen > 255) ? 255 : rej_seen;
`else
        return 0;
`endif
    endfunction

    // Drive one cycle of stimulus; an accepted pair becomes an expected launch.
    task automatic drive_cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        pair_t p;
        in_valid = v;
        in_a = a;
        in_b = b;
        if (v && in_ready) begin
            p.a = a;
            p.b = b;
            exp_q.push_back(p);
        end
        if (v && !in_ready) rej_seen++;
        @(negedge clk);
    endtask

    task automatic check_drain();
        for (int i = 1; i <= P; i++) begin
            @(negedge clk);
            check("drain_in_ready", int'(in_ready), int'(i == P));
            check("drain_busy", int'(busy), int'(i < P));
        end
    endtask

    // Monitor: every launch pops the scoreboard, then the whole 6-cycle frame is checked.
    task automatic monitor();
        pair_t        cur;
        int           rem = 0;
        int           last_en = -1;
        int           cyc = 0;
        int           pos;
        int           sp;
        logic [W-1:0] ra = '0;
        logic [W-1:0] rb = '0;
        cur = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                rem = 0;
                last_en = -1;
            end else if (add_en) begin
                if (last_en >= 0) begin
                    sp = cyc - last_en;
                    n_cmp++;
                    if (sp < P) begin
                        n_bad++;
                        $display("FAIL launch_spacing: got %0d cycles, need at least %0d", sp, P);
                    end
                end
                last_en = cyc;
                en_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_launch: got launch a=%b b=%b, expected no launch", add_a, add_b);
                    rem = 0;
                end else begin
                    cur = exp_q.pop_front();
                    $display("launch a=%b b=%b at cycle %0d", cur.a, cur.b, cyc);
                    check("msb_a", int'(add_a), int'(cur.a[W-1]));
                    check("msb_b", int'(add_b), int'(cur.b[W-1]));
                    ra = '0;
                    rb = '0;
                    ra[0] = add_a;
                    rb[0] = add_b;
                    rem = P - 1;
                end
            end else if (rem > 0) begin
                pos = P - rem;
                if (pos < W) begin
                    check("bit_a", int'(add_a), int'(cur.a[W-1-pos]));
                    check("bit_b", int'(add_b), int'(cur.b[W-1-pos]));
                    ra = {ra[W-2:0], add_a};
                    rb = {rb[W-2:0], add_b};
                    if (pos == W - 1) rx_q.push_back({ra, rb});
                end else begin
                    check("gap_a", int'(add_a), 0);
                    check("gap_b", int'(add_b), 0);
                end
                rem--;
            end else begin
                check("idle_a", int'(add_a), 0);
                check("idle_b", int'(add_b), 0);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sums [4];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        sums[0] = 2; sums[1] = 6; sums[2] = 2; sums[3] = 3;

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_add_en", int'(add_en), 0);
        check("rst_add_a", int'(add_a), 0);
        check("rst_add_b", int'(add_b), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_level", int'(level), 0);
        check("rst_rej_cnt", int'(rej_cnt), 0);
        rst = 1'b0;
        rej_seen = 0;
        check_drain();

        // Single push in IDLE: launch one edge after the push edge
        drive_cycle(1'b1, 2'b10, 2'b11);
        in_valid = 1'b0;
        check("t1_level", int'(level), 1);
        check("t1_no_early_en", int'(add_en), 0);
        @(negedge clk);
        check("t1_add_en", int'(add_en), 1);
        check("t1_level_popped", int'(level), 0);
        check("t1_busy", int'(busy), 1);
        repeat (8) @(negedge clk);
        check("t1_busy_done", int'(busy), 0);

        // Back-to-back launches
        rx_q.delete();
        en_times.delete();
        drive_cycle(1'b1, 2'b01, 2'b01);
        drive_cycle(1'b1, 2'b11, 2'b11);
        drive_cycle(1'b1, 2'b00, 2'b10);
        drive_cycle(1'b1, 2'b10, 2'b01);
        in_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("t2_launch_count", en_times.size(), 4);
        for (int i = 1; i < en_times.size(); i++)
            check("t2_period", en_times[i] - en_times[i-1], P);
        check("t2_rx_count", rx_q.size(), 4);
        for (int i = 0; i < rx_q.size() && i < 4; i++) begin
            ra = rx_q[i][2*W-1:W];
            rb = rx_q[i][W-1:0];
            check("t2_adder_sum", int'(ra) + int'(rb), sums[i]);
        end

        // Fill while shifting, then push against full across a GAP-end pop
        for (int k = 0; k < 8; k++) begin
            check("t3_in_ready", int'(in_ready), int'(k < 5));
            drive_cycle(1'b1, W'($urandom), W'($urandom));
            if (k >= 4 && k <= 6) check("t3_level_full", int'(level), D);
        end
        in_valid = 1'b0;
        check("t3_level_after_pop", int'(level), D - 1);
        check("t3_in_ready_after_pop", int'(in_ready), 1);
        check("t3_rej_cnt", int'(rej_cnt), rej_expected());
        repeat (30) @(negedge clk);
        check("t3_drained", exp_q.size(), 0);

        // Reset during the second SHIFT cycle
        drive_cycle(1'b1, 2'b01, 2'b11);
        drive_cycle(1'b1, 2'b10, 2'b10);
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_level_pre_rst", int'(level), 1);
        #2 rst = 1'b1;
        exp_q.delete();
        rej_seen = 0;
        #1;
        check("t4_rst_add_a", int'(add_a), 0);
        check("t4_rst_add_b", int'(add_b), 0);
        check("t4_rst_level", int'(level), 0);
        check("t4_rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        check_drain();
        drive_cycle(1'b1, 2'b11, 2'b01);
        in_valid = 1'b0;
        check("t4_fresh_no_early_en", int'(add_en), 0);
        @(negedge clk);
        check("t4_fresh_add_en", int'(add_en), 1);
        repeat (10) @(negedge clk);

        // Random traffic
        for (int i = 0; i < 200; i++)
            drive_cycle(($urandom_range(0, 2) == 0), W'($urandom), W'($urandom));
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("t5_drained", exp_q.size(), 0);
        check("t5_level", int'(level), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_rej_cnt", int'(rej_cnt), rej_expected());

        // Saturation under continuous pressure
        for (int i = 0; i < 400; i++)
            drive_cycle(1'b1, W'($urandom), W'($urandom));
        in_valid = 1'b0;
        check("t6_rej_cnt_sat", int'(rej_cnt), rej_expected());
        repeat (40) @(negedge clk);
        check("t6_drained", exp_q.size(), 0);
        check("t6_level", int'(level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
